fadd_share_arbiter: RTL

Shares one pipelined float_add unit (32-bit IEEE-754 single, fixed latency) between NUM_REQ VLIW issue lanes. Round-robin arbitration grants at most one requester per cycle and registers its operands into the adder. A tag pipeline tracks each in-flight operation so the sum returns to the lane that issued it. It sits between the lane issue logic and the shared FADD datapath.

---
 rtl/fadd_arb_pkg.sv | 18 +
 rtl/fadd_share_arbiter_if.sv | 29 ++
 rtl/fadd_share_arbiter_rr.sv | 57 +++++
 rtl/fadd_share_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fadd_arb_pkg.sv
// Shared types and helpers for the float-add sharing arbiter.
// Tags carry a valid bit and a requester id sized for up to 8 lanes.
package fadd_arb_pkg;

    localparam int FP_W         = 32;
    localparam int FADD_LAT_DEF = 3;
    localparam int ID_W_MAX     = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    function automatic logic [7:0] onehot(input logic [ID_W_MAX-1:0] id);
        onehot = 8'd1 << id;
    endfunction

endpackage

// File: rtl/fadd_share_arbiter_if.sv
// Lane request / response and float_add datapath bundle.
// slave = arbiter side, master = lanes plus adder side.
interface fadd_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import fadd_arb_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*FP_W-1:0] req_a;
    logic [NUM_REQ*FP_W-1:0] req_b;
    logic [FP_W-1:0]         fadd_a;
    logic [FP_W-1:0]         fadd_b;
    logic [FP_W-1:0]         fadd_out;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [FP_W-1:0]         rsp_data;
    logic                    busy;

    modport slave (
        input  req_valid, req_a, req_b, fadd_out,
        output req_ready, fadd_a, fadd_b, rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, fadd_out,
        input  req_ready, fadd_a, fadd_b, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/fadd_share_arbiter_rr.sv
// Round-robin arbiter: search starts at the pointer, wraps modulo
// NUM_REQ, pointer moves past the winner when adv is strobed.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic [ID_W-1:0]    ptr_q
);

    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] idx;
    logic            found;

    // First requesting lane at or above the pointer, wrapping around
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    // Pointer lands just past the lane that completed a handshake
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + ID_W'(1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fadd_share_arbiter.sv
// Shares one pipelined float_add between NUM_REQ lanes; a tag pipe
// routes each sum back. Optional FADD_ARB_STATS_EN adds grant counters.
module fadd_share_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int FADD_LAT = FADD_LAT_DEF,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fadd_share_arbiter_if.slave  bus
`ifdef FADD_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]      stat_sel,
    output logic [15:0]          stat_cnt
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    ptr;
    logic               hs;

    logic [FP_W-1:0]    a_sel;
    logic [FP_W-1:0]    b_sel;
    logic [FP_W-1:0]    fadd_a_q, fadd_a_d;
    logic [FP_W-1:0]    fadd_b_q, fadd_b_d;
    tag_t               tag_q [FADD_LAT];
    tag_t               tag_d [FADD_LAT];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [FP_W-1:0]    rsp_data_q, rsp_data_d;
    logic [7:0]         oh;
    logic               busy_w;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .adv     (hs),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .ptr_q   (ptr)
    );

    assign bus.req_ready = gnt;
    assign hs            = |(bus.req_valid & gnt);

    // Operand mux for the granted lane
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = bus.req_a[i*FP_W +: FP_W];
                b_sel = bus.req_b[i*FP_W +: FP_W];
            end
        end
    end

    // Issue stage and tag shift; operands hold when idle
    always_comb begin
        fadd_a_d = hs ? a_sel : fadd_a_q;
        fadd_b_d = hs ? b_sel : fadd_b_q;
        tag_d[0] = '{valid: hs, id: ID_W_MAX'(gnt_idx)};
        for (int k = 1; k < FADD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Result capture steered by the oldest tag
    always_comb begin
        oh          = onehot(tag_q[FADD_LAT-1].id);
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_q[FADD_LAT-1].valid) begin
            rsp_valid_d = oh[NUM_REQ-1:0];
            rsp_data_d  = bus.fadd_out;
        end
    end

    // Anything still travelling through the adder
    always_comb begin
        busy_w = 1'b0;
        for (int k = 0; k < FADD_LAT; k++) begin
            busy_w = busy_w | tag_q[k].valid;
        end
    end

    // Datapath, tag and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fadd_a_q    <= '0;
            fadd_b_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int k = 0; k < FADD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            fadd_a_q    <= fadd_a_d;
            fadd_b_q    <= fadd_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int k = 0; k < FADD_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign bus.fadd_a    = fadd_a_q;
    assign bus.fadd_b    = fadd_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_w;

`ifdef FADD_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    // Saturating per-lane grant counters
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && bus.req_valid[i] && cnt_q[i] != 16'hFFFF) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stat_cnt = (int'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : '0;
`endif

endmodule
